// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
//
// Word format is {sign, exponent[EXP_W], mantissa[MAN_W]}, hidden leading one,
// exponent 0 treated as zero, truncation rounding, no NaN/Inf handling.
//
// Stages:
//   S1  unpack, magnitude compare, select the larger operand, exponent difference
//   S2  align the smaller significand and add/subtract
//   S3  normalise, detect zero/overflow, pack into the output register
//
// Ports:
//   MAIN_CLK   clock, all state on the rising edge
//   RST        synchronous active-high reset
//   in_valid   operand pair presented
//   in_ready   pair accepted this cycle
//   a, b       operands
//   sub        1: a-b, 0: a+b
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   ab         result word
//   ovf        overflow flag, qualified by out_valid
module fp_add_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int MAX_SHIFT = 14
) (
    input  logic                     MAIN_CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     ab,
    output logic                     ovf
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SIG_W   = MAN_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] SHIFT_LIMIT = EXP_W'(MAX_SHIFT);

    // ------------------------------------------------------------------
    // Flow control: the whole pipe advances together.
    // ------------------------------------------------------------------
    logic adv;
    logic out_valid_reg;

    assign adv = !out_valid_reg | out_ready;
    // Anything presented while RST is high is flushed by the reset itself,
    // so the input side can advertise ready throughout reset.
    assign in_ready = adv | RST;

    // ------------------------------------------------------------------
    // S1: unpack / compare / select
    // ------------------------------------------------------------------
    logic             b_sign;
    logic             a_larger;
    logic [W-2:0]     big_mag;
    logic [W-2:0]     small_mag;
    logic             big_sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_diff;
    logic             pass_next;

    always_comb begin
        b_sign    = b[W-1] ^ sub;
        // {exponent, mantissa} compares as an unsigned magnitude: exponent
        // first, mantissa on a tie.
        a_larger  = (a[W-2:0] >= b[W-2:0]);
        big_mag   = a_larger ? a[W-2:0] : b[W-2:0];
        small_mag = a_larger ? b[W-2:0] : a[W-2:0];
        big_sign  = a_larger ? a[W-1] : b_sign;
        eff_sub   = a[W-1] ^ b_sign;
        exp_diff  = big_mag[W-2:MAN_W] - small_mag[W-2:MAN_W];
        // Small operand is zero, or too far below to be aligned: the larger
        // operand goes through untouched.
        pass_next = (small_mag[W-2:MAN_W] == '0) || (exp_diff > SHIFT_LIMIT);
    end

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic             s1_eff_sub_reg;
    logic             s1_pass_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [MAN_W-1:0] s1_big_man_reg;
    logic [MAN_W-1:0] s1_small_man_reg;
    logic [EXP_W-1:0] s1_diff_reg;

    // ------------------------------------------------------------------
    // S2: align and add/subtract
    // ------------------------------------------------------------------
    logic [SIG_W-1:0] sig_big;
    logic [SIG_W-1:0] sig_small;
    logic [SIG_W-1:0] sum_next;

    always_comb begin
        // Top bit is headroom for the addition carry.
        sig_big   = {2'b01, s1_big_man_reg};
        sig_small = {2'b01, s1_small_man_reg} >> s1_diff_reg;
        sum_next  = s1_eff_sub_reg ? (sig_big - sig_small) : (sig_big + sig_small);
    end

    logic             s2_valid_reg;
    logic             s2_sign_reg;
    logic             s2_eff_sub_reg;
    logic             s2_pass_reg;
    logic [EXP_W-1:0] s2_exp_reg;
    logic [MAN_W-1:0] s2_big_man_reg;
    logic [SIG_W-1:0] s2_sum_reg;

    // ------------------------------------------------------------------
    // S3: normalise and pack
    // ------------------------------------------------------------------
    int               lead;
    int               lz;
    int               exp_norm;
    logic [MAN_W-1:0] man_norm;
    logic             res_zero;
    logic [W-1:0]     ab_next;
    logic             ovf_next;

    always_comb begin
        // Leading-one position over the low MAN_W+1 bits; the subtract
        // result never sets the carry bit because the larger magnitude is
        // always the minuend.
        lead = 0;
        for (int i = 0; i <= MAN_W; i++) begin
            if (s2_sum_reg[i]) begin
                lead = i;
            end
        end
        lz = MAN_W - lead;

        res_zero = 1'b0;
        exp_norm = int'(s2_exp_reg);
        man_norm = s2_sum_reg[MAN_W-1:0];
        if (s2_eff_sub_reg) begin
            exp_norm = int'(s2_exp_reg) - lz;
            // Shifting only the stored bits drops the leading one past the top.
            man_norm = s2_sum_reg[MAN_W-1:0] << lz;
            res_zero = (s2_sum_reg == '0) || (exp_norm <= 0);
        end else if (s2_sum_reg[SIG_W-1]) begin
            exp_norm = int'(s2_exp_reg) + 1;
            man_norm = s2_sum_reg[MAN_W:1];
        end

        ab_next  = '0;
        ovf_next = 1'b0;
        if (!s2_valid_reg) begin
            ab_next = '0;
        end else if (s2_pass_reg) begin
            ab_next = {s2_sign_reg, s2_exp_reg, s2_big_man_reg};
        end else if (res_zero) begin
            ab_next = '0;
        end else if (exp_norm >= EXP_MAX) begin
            ab_next  = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_next = 1'b1;
        end else begin
            ab_next = {s2_sign_reg, EXP_W'(exp_norm), man_norm};
        end
    end

    logic [W-1:0] ab_reg;
    logic         ovf_reg;

    // ------------------------------------------------------------------
    // Valid bits and output register (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge MAIN_CLK) begin
        if (RST) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            ab_reg        <= '0;
            ovf_reg       <= 1'b0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            ab_reg        <= ab_next;
            ovf_reg       <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath stage registers (qualified by the valid bits, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge MAIN_CLK) begin
        if (adv) begin
            s1_sign_reg      <= big_sign;
            s1_eff_sub_reg   <= eff_sub;
            s1_pass_reg      <= pass_next;
            s1_exp_reg       <= big_mag[W-2:MAN_W];
            s1_big_man_reg   <= big_mag[MAN_W-1:0];
            s1_small_man_reg <= small_mag[MAN_W-1:0];
            s1_diff_reg      <= exp_diff;

            s2_sign_reg      <= s1_sign_reg;
            s2_eff_sub_reg   <= s1_eff_sub_reg;
            s2_pass_reg      <= s1_pass_reg;
            s2_exp_reg       <= s1_exp_reg;
            s2_big_man_reg   <= s1_big_man_reg;
            s2_sum_reg       <= sum_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign ab        = ab_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed bench for fp_add_pipe with a result scoreboard.
// Expected results are pushed when an operand pair is accepted and compared
// in order when the DUT hands a result downstream.
module tb_fp_add_pipe;

    logic        MAIN_CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ab;
    logic        ovf;

    always #5 MAIN_CLK = ~MAIN_CLK;

    fp_add_pipe dut (
        .MAIN_CLK  (MAIN_CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ab        (ab),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [31:0] ab;
        logic        ovf;
        logic        lat_chk;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] drv_exp_ab;
    logic        drv_exp_ovf;
    logic        lat_check_en;

    // Monitor: all handshake signals are stable at the falling edge and
    // describe the transfer that happens on the following rising edge.
    always @(negedge MAIN_CLK) begin
        exp_t e;
        cyc++;
        if (RST) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result observed=%h expected=no_output", ab);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    $display("txn cyc=%0d ab=%h ovf=%b exp_ab=%h exp_ovf=%b", cyc, ab, ovf, e.ab, e.ovf);
                    checks++;
                    assert (ab === e.ab) else begin
                        errors++;
                        $error("FAIL result_ab observed=%h expected=%h", ab, e.ab);
                    end
                    checks++;
                    assert (ovf === e.ovf) else begin
                        errors++;
                        $error("FAIL result_ovf observed=%b expected=%b", ovf, e.ovf);
                    end
                    if (e.lat_chk) begin
                        checks++;
                        assert ((cyc - e.acc_cyc) === 3) else begin
                            errors++;
                            $error("FAIL latency observed=%0d expected=3", cyc - e.acc_cyc);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.ab      = drv_exp_ab;
                e.ovf     = drv_exp_ovf;
                e.lat_chk = lat_check_en;
                e.acc_cyc = cyc;
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present one pair and hold it until accepted; returns #1 after the
    // accepting edge so a following call forms back-to-back traffic.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input logic [31:0] eab, input logic eovf);
        int n = 0;
        a           = ta;
        b           = tb_v;
        sub         = ts;
        drv_exp_ab  = eab;
        drv_exp_ovf = eovf;
        in_valid    = 1'b1;
        @(negedge MAIN_CLK);
        while (!in_ready && n < 50) begin
            @(negedge MAIN_CLK);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=in_ready_low expected=accept");
        end
        @(posedge MAIN_CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge MAIN_CLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb_q.size());
        end
        @(posedge MAIN_CLK);
        #1;
    endtask

    initial begin
        RST          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        sub          = 1'b0;
        out_ready    = 1'b1;
        drv_exp_ab   = '0;
        drv_exp_ovf  = 1'b0;
        lat_check_en = 1'b0;

        // Reset state
        repeat (3) @(posedge MAIN_CLK);
        @(negedge MAIN_CLK);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_ab",        ab,             32'h0000_0000);
        check("reset_ovf",       32'(ovf),       32'd0);
        @(posedge MAIN_CLK);
        #1;
        RST = 1'b0;

        // Directed vectors, back-to-back, no stalls: exact latency and order.
        // The first one is offered right after reset release.
        lat_check_en = 1'b1;
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0); // 1+1
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0); // 3-1
        send(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 1'b0); // exact cancel
        send(32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 1'b0); // diff 24 > limit
        send(32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 1'b1); // overflow
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0); // 1+2
        send(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 1'b0); // 1-2
        send(32'h0000_0000, 32'hC0A0_0000, 1'b0, 32'hC0A0_0000, 1'b0); // 0+(-5)
        send(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0); // denormal flushed
        send(32'h3F80_0000, 32'h3880_0000, 1'b0, 32'h3F80_0200, 1'b0); // diff 14, aligned
        send(32'h3F80_0000, 32'h3800_0000, 1'b0, 32'h3F80_0000, 1'b0); // diff 15, passed
        send(32'h3F80_0000, 32'h3880_0001, 1'b0, 32'h3F80_0200, 1'b0); // truncation
        send(32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h0000_0000, 1'b0); // exponent underflow
        send(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 1'b0); // full left normalise
        send(32'h4040_0000, 32'hBF80_0000, 1'b0, 32'h4000_0000, 1'b0); // 3+(-1)
        send(32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 1'b0); // 1-(-1)
        send(32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 1'b0); // -2+1
        drain();

        // Backpressure: fill the pipe, hold out_ready low for 4 cycles.
        lat_check_en = 1'b0;
        out_ready    = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0);
        send(32'h4040_0000, 32'hBF80_0000, 1'b0, 32'h4000_0000, 1'b0);
        send(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 1'b0);
        a           = 32'h3F80_0000;
        b           = 32'h4000_0000;
        sub         = 1'b1;
        drv_exp_ab  = 32'hBF80_0000;
        drv_exp_ovf = 1'b0;
        in_valid    = 1'b1;
        repeat (4) begin
            @(negedge MAIN_CLK);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_ab_hold",   ab,             32'h4040_0000);
        end
        @(posedge MAIN_CLK);
        #1;
        out_ready = 1'b1;
        @(negedge MAIN_CLK);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge MAIN_CLK);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with three results in flight.
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
        send(32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 1'b1);
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0);
        RST = 1'b1;
        @(negedge MAIN_CLK);
        check("flush_in_ready_during_reset", 32'(in_ready), 32'd1);
        @(negedge MAIN_CLK);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ab",        ab,             32'h0000_0000);
        check("flush_ovf",       32'(ovf),       32'd0);
        @(posedge MAIN_CLK);
        #1;
        RST       = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge MAIN_CLK);
            check("flush_no_stale_output", 32'(out_valid), 32'd0);
        end
        @(posedge MAIN_CLK);
        #1;
        lat_check_en = 1'b1;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter MAX_SHIFT, default 14, meaning largest alignment shift applied; larger exponent differences return the larger operand unchanged.
REQ-004 SHALL have port MAIN_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-008 SHALL have port a, input, W bits: operand A as {sign, exponent, mantissa}.
REQ-009 SHALL have port b, input, W bits: operand B in the same format.
REQ-010 SHALL have port sub, input, 1 bit: 1 computes a-b by inverting b's sign before processing; 0 computes a+b.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port ab, output, W bits: result word.
REQ-014 SHALL have port ovf, output, 1 bit: overflow flag, qualified by out_valid.

Function
REQ-015 SHALL run three stages: S1 unpack/compare/select larger magnitude; S2 align (right shift by exponent difference) and add/subtract; S3 normalise/pack.
REQ-016 SHALL use one advance enable, adv = !out_valid | out_ready; in_ready = adv; all stage registers and valid bits load only when adv=1.
REQ-017 SHALL give latency of exactly 3 cycles from acceptance (in_valid & in_ready) to out_valid with no stalls; throughput one result per cycle.
REQ-018 SHALL hold ab, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL treat an operand with exponent 0 as zero (denormals flushed); zero+x returns x with x's sign.
REQ-020 SHALL select the larger magnitude by exponent, then mantissa on equal exponents; result sign follows that operand.
REQ-021 SHALL form the significand as {01, mantissa} (MAN_W+2 bits), shifting the smaller right by the exponent difference with truncation.
REQ-022 SHALL return the larger operand unchanged when the exponent difference exceeds MAX_SHIFT.
REQ-023 SHALL, on addition carry-out, shift right one and increment exponent.
REQ-024 SHALL, on subtraction, left-normalise by leading-one position over the full MAN_W+1 bits, decrementing exponent by shift amount.
REQ-025 SHALL output +0 (all zeros) for an exact zero difference or when the normalised exponent would be less than or equal to 0.
REQ-026 SHALL output sign, all-ones exponent and zero mantissa, with ovf=1, when the exponent would reach all-ones; ovf=0 otherwise.
REQ-027 SHALL treat rounding as truncation only; NaN/Inf inputs are not special-cased.

Reset
REQ-028 SHALL, on RST=1 at a clock edge, clear all stage valid bits so out_valid=0, ab=0, ovf=0, discarding in-flight data.
REQ-029 SHALL hold in_ready=1 during and after reset.
REQ-030 SHALL accept a new operand on the first edge after RST deasserts.

Verification
REQ-031 SHALL cover: a=3F800000, b=3F800000, sub=0 -> ab=40000000 three cycles later, ovf=0.
REQ-032 SHALL cover: a=40400000, b=3F800000, sub=1 -> ab=40000000; and a=3FC00000, b=3FC00000, sub=1 -> ab=00000000.
REQ-033 SHALL cover: a=4B800000, b=3F800000, MAX_SHIFT=14 -> ab=4B800000 (difference 24 exceeds limit).
REQ-034 SHALL cover: a=7F000000, b=7F000000, sub=0 -> ab=7F800000, ovf=1.
REQ-035 SHALL cover: back-to-back inputs with out_ready low for 4 cycles -> in_ready=0 while full, ab held, no result lost or duplicated, order preserved.
REQ-036 SHALL cover: RST asserted with 3 results in flight -> next cycle out_valid=0, ab=0, and none of those results appear later.
